// File: rtl/nrisc_ula_mc.sv
// NRISC ULA, multi-cycle: single-cycle ALU ops plus iterative unsigned MUL/MULH/DIVU/REMU
// behind a start/busy/done handshake with registered result and {neg, zero, carry} flags.
module nrisc_ula_mc #(
  parameter int TAM = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ULA_start,
  input  logic [3:0]     ULA_ctrl,
  input  logic [TAM-1:0] ULA_A,
  input  logic [TAM-1:0] ULA_B,
  input  logic           incdec,
  output logic [TAM-1:0] ULA_OUT,
  output logic [2:0]     ULA_flags,
  output logic           ULA_busy,
  output logic           ULA_done
);
  localparam int            CW       = $clog2(TAM + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TAM);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;

  logic [CW-1:0]  cnt;
  logic [TAM-1:0] acc, lo, opnd, acc_n, lo_n;
  logic [1:0]     iop;
  logic           dz;
  logic           iter;

  logic [TAM-1:0] b_eff, sc_res, it_res;
  logic           sc_cy, it_cy;
  logic [TAM:0]   add_w, sub_w, mul_sum, div_r, div_t;

  assign iter     = (ULA_ctrl[3:2] == 2'b10);
  assign ULA_busy = (state == RUN);

  always_comb begin
    b_eff  = (incdec && ULA_ctrl[3:1] == 3'b000) ? TAM'(1) : ULA_B;
    add_w  = {1'b0, ULA_A} + {1'b0, b_eff};
    sub_w  = {1'b0, ULA_A} - {1'b0, b_eff};
    sc_res = '0;
    sc_cy  = 1'b0;
    case (ULA_ctrl)
      4'b0000: begin sc_res = add_w[TAM-1:0]; sc_cy = add_w[TAM]; end
      4'b0001: begin sc_res = sub_w[TAM-1:0]; sc_cy = sub_w[TAM]; end
      4'b0010: sc_res = ULA_A & ULA_B;
      4'b0011: sc_res = ULA_A | ULA_B;
      4'b0100: sc_res = ULA_A ^ ULA_B;
      4'b0111: sc_res = ~ULA_A;
      4'b0101: begin sc_res = {ULA_A[TAM-1], ULA_A[TAM-1:1]}; sc_cy = ULA_A[0]; end
      4'b0110: begin sc_res = {ULA_A[TAM-2:0], 1'b0}; sc_cy = ULA_A[TAM-1]; end
      4'b1101: sc_res = {ULA_A[0], ULA_A[TAM-1:1]};
      4'b1110: sc_res = {ULA_A[TAM-2:0], ULA_A[TAM-1]};
      default: ;
    endcase
  end

  // MUL: {acc,lo} shifts right, lo starts as B. DIV: {acc,lo} shifts left, lo starts as A
  // and collects quotient bits. With B=0 the restoring step yields all-ones / A naturally.
  always_comb begin
    mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    div_r   = {acc, lo[TAM-1]};
    div_t   = div_r - {1'b0, opnd};
    if (iop[1]) begin
      acc_n = div_t[TAM] ? div_r[TAM-1:0] : div_t[TAM-1:0];
      lo_n  = {lo[TAM-2:0], ~div_t[TAM]};
    end else begin
      acc_n = mul_sum[TAM:1];
      lo_n  = {mul_sum[0], lo[TAM-1:1]};
    end
    case (iop)
      2'b00:   begin it_res = lo_n;  it_cy = |acc_n; end
      2'b01:   begin it_res = acc_n; it_cy = 1'b0;   end
      2'b10:   begin it_res = lo_n;  it_cy = dz;     end
      default: begin it_res = acc_n; it_cy = dz;     end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (ULA_start && iter) state_n = RUN;
      RUN:     if (cnt == CNT_LAST)   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ULA_OUT   <= '0;
      ULA_flags <= 3'b000;
      ULA_done  <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      lo        <= '0;
      opnd      <= '0;
      iop       <= 2'b00;
      dz        <= 1'b0;
    end else begin
      ULA_done <= 1'b0;
      if (state == IDLE) begin
        if (ULA_start && iter) begin
          cnt  <= CNT_LOAD;
          acc  <= '0;
          lo   <= ULA_ctrl[1] ? ULA_A : ULA_B;
          opnd <= ULA_ctrl[1] ? ULA_B : ULA_A;
          iop  <= ULA_ctrl[1:0];
          dz   <= (ULA_B == '0);
        end else if (ULA_start) begin
          ULA_OUT   <= sc_res;
          ULA_flags <= {sc_res[TAM-1], sc_res == '0, sc_cy};
          ULA_done  <= 1'b1;
        end
      end else begin
        cnt <= cnt - CNT_LAST;
        acc <= acc_n;
        lo  <= lo_n;
        if (cnt == CNT_LAST) begin
          ULA_OUT   <= it_res;
          ULA_flags <= {it_res[TAM-1], it_res == '0, it_cy};
          ULA_done  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_nrisc_ula_mc.sv
// Bench for nrisc_ula_mc: TAM=4 and TAM=16 instances share stimulus; an arithmetic model
// predicts done/busy/result/flags every cycle, plus directed literal checks.
module tb_nrisc_ula_mc;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ctrl = 4'h0;
  logic [15:0] a = 16'h0, b = 16'h0;
  logic        inc = 1'b0;

  logic [3:0]  out4;
  logic [15:0] out16;
  logic [2:0]  fl4, fl16;
  logic        busy4, busy16, done4, done16;

  int total = 0, passed = 0;

  always #5 clk = ~clk;

  nrisc_ula_mc #(.TAM(4)) u4 (
    .clk(clk), .rst(rst), .ULA_start(start), .ULA_ctrl(ctrl),
    .ULA_A(a[3:0]), .ULA_B(b[3:0]), .incdec(inc),
    .ULA_OUT(out4), .ULA_flags(fl4), .ULA_busy(busy4), .ULA_done(done4));

  nrisc_ula_mc #(.TAM(16)) u16 (
    .clk(clk), .rst(rst), .ULA_start(start), .ULA_ctrl(ctrl),
    .ULA_A(a), .ULA_B(b), .incdec(inc),
    .ULA_OUT(out16), .ULA_flags(fl16), .ULA_busy(busy16), .ULA_done(done16));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    else passed++;
  endtask

  // Returns {neg, zero, carry, result}, computed with plain integer arithmetic.
  function automatic logic [18:0] ref_op(input int w, input logic [3:0] op,
                                         input logic [15:0] ai, input logic [15:0] bi,
                                         input logic incd);
    longint m, x, y, yy, r, p, msb;
    logic c;
    logic [63:0] rv;
    m   = (64'sd1 <<< w) - 64'sd1;
    x   = longint'(ai) & m;
    y   = longint'(bi) & m;
    yy  = (incd && op <= 4'd1) ? 64'sd1 : y;
    msb = (x >>> (w - 1)) & 64'sd1;
    p   = x * y;
    r   = 0;
    c   = 1'b0;
    case (op)
      4'd0:  begin r = (x + yy) & m; c = ((x + yy) >>> w) != 0; end
      4'd1:  begin r = (x - yy) & m; c = (x < yy); end
      4'd2:  r = x & y;
      4'd3:  r = x | y;
      4'd4:  r = x ^ y;
      4'd7:  r = ~x & m;
      4'd5:  begin r = (x >>> 1) | (msb <<< (w - 1)); c = (x & 1) != 0; end
      4'd6:  begin r = (x <<< 1) & m; c = msb != 0; end
      4'd13: r = (x >>> 1) | ((x & 1) <<< (w - 1));
      4'd14: r = ((x <<< 1) & m) | msb;
      4'd8:  begin r = p & m; c = (p >>> w) != 0; end
      4'd9:  r = p >>> w;
      4'd10: begin r = (y == 0) ? m : x / y; c = (y == 0); end
      4'd11: begin r = (y == 0) ? x : x % y; c = (y == 0); end
      default: r = 0;
    endcase
    rv = 64'(r);
    return {((r >>> (w - 1)) & 1) != 0, r == 0, c, rv[15:0]};
  endfunction

  // Per-instance model state: index 0 is TAM=4, index 1 is TAM=16.
  int          wid [2] = '{4, 16};
  int          remc [2] = '{0, 0};
  logic [15:0] pend_o [2], exp_o [2] = '{16'h0, 16'h0};
  logic [2:0]  pend_f [2], exp_f [2] = '{3'b0, 3'b0};
  logic        exp_d [2] = '{1'b0, 1'b0};
  logic [15:0] act_o [2];
  logic [2:0]  act_f [2];
  logic        act_b [2], act_d [2];

  assign act_o[0] = {12'h0, out4};
  assign act_o[1] = out16;
  assign act_f[0] = fl4;
  assign act_f[1] = fl16;
  assign act_b[0] = busy4;
  assign act_b[1] = busy16;
  assign act_d[0] = done4;
  assign act_d[1] = done16;

  always @(posedge clk) begin
    logic [18:0] r;
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        remc[i] = 0; exp_o[i] = 16'h0; exp_f[i] = 3'b0; exp_d[i] = 1'b0;
      end else begin
        exp_d[i] = 1'b0;
        if (remc[i] > 0) begin
          remc[i]--;
          if (remc[i] == 0) begin
            exp_o[i] = pend_o[i]; exp_f[i] = pend_f[i]; exp_d[i] = 1'b1;
          end
        end else if (start) begin
          r = ref_op(wid[i], ctrl, a, b, inc);
          if (ctrl[3:2] == 2'b10) begin
            remc[i] = wid[i]; pend_o[i] = r[15:0]; pend_f[i] = r[18:16];
          end else begin
            exp_o[i] = r[15:0]; exp_f[i] = r[18:16]; exp_d[i] = 1'b1;
          end
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("done_w%0d", wid[i]), 32'(act_d[i]), 32'(exp_d[i]));
      chk($sformatf("busy_w%0d", wid[i]), 32'(act_b[i]), 32'(remc[i] > 0));
      chk($sformatf("out_w%0d", wid[i]), 32'(act_o[i]), 32'(exp_o[i]));
      chk($sformatf("flags_w%0d", wid[i]), 32'(act_f[i]), 32'(exp_f[i]));
    end
  end

  task automatic issue(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv,
                       input logic incd);
    @(negedge clk);
    start = 1'b1; ctrl = op; a = av; b = bv; inc = incd;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done16(output int n);
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!done16 && n < 40);
    chk("done16_timeout", 32'(done16), 32'd1);
  endtask

  initial begin
    int n;
    #1;
    chk("rst_out16", 32'(out16), 32'h0);
    chk("rst_flags16", 32'(fl16), 32'h0);
    chk("rst_busy16", 32'(busy16), 32'h0);
    chk("rst_done16", 32'(done16), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    issue(4'b0000, 16'h0007, 16'h0001, 1'b0);
    chk("add4_out", 32'(out4), 32'h8);
    chk("add4_flags", 32'(fl4), 32'b100);
    chk("add4_done", 32'(done4), 32'h1);
    issue(4'b0001, 16'h0003, 16'h0005, 1'b0);
    chk("sub4_out", 32'(out4), 32'he);
    chk("sub4_flags", 32'(fl4), 32'b101);
    issue(4'b0001, 16'h0001, 16'h000f, 1'b1);
    chk("dec4_out", 32'(out4), 32'h0);
    chk("dec4_flags", 32'(fl4), 32'b010);

    issue(4'b1000, 16'h0100, 16'h0100, 1'b0);
    wait_done16(n);
    chk("mul16_latency", 32'(n), 32'd16);
    chk("mul16_out", 32'(out16), 32'h0);
    chk("mul16_flags", 32'(fl16), 32'b011);
    issue(4'b1001, 16'h0100, 16'h0100, 1'b0);
    wait_done16(n);
    chk("mulh16_out", 32'(out16), 32'h1);
    issue(4'b1010, 16'd100, 16'd7, 1'b0);
    wait_done16(n);
    chk("divu16_out", 32'(out16), 32'd14);
    issue(4'b1011, 16'd100, 16'd7, 1'b0);
    wait_done16(n);
    chk("remu16_out", 32'(out16), 32'd2);
    issue(4'b1010, 16'h1234, 16'h0000, 1'b0);
    wait_done16(n);
    chk("div0_out", 32'(out16), 32'hffff);
    chk("div0_flags", 32'(fl16), 32'b101);

    // ADD arrives while the MUL is running and must be dropped
    issue(4'b1000, 16'h0003, 16'h0005, 1'b0);
    @(negedge clk);
    issue(4'b0000, 16'h00aa, 16'h0001, 1'b0);
    wait_done16(n);
    chk("ign_out", 32'(out16), 32'h000f);
    chk("ign_flags", 32'(fl16), 32'b000);

    // asynchronous reset in the middle of a MUL
    issue(4'b1000, 16'h0123, 16'h0045, 1'b0);
    repeat (7) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_out16", 32'(out16), 32'h0);
    chk("arst_flags16", 32'(fl16), 32'h0);
    chk("arst_busy16", 32'(busy16), 32'h0);
    chk("arst_done16", 32'(done16), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      ctrl  = 4'($urandom);
      a     = 16'($urandom);
      b     = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      inc   = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
